// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the TAP controller: state encoding, opcodes
// and the next-state function of the 1149.1 state diagram.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        ST_EX2_DR   = 4'h0,
        ST_EX1_DR   = 4'h1,
        ST_SH_DR    = 4'h2,
        ST_PAUSE_DR = 4'h3,
        ST_SEL_IR   = 4'h4,
        ST_UPD_DR   = 4'h5,
        ST_CAP_DR   = 4'h6,
        ST_SEL_DR   = 4'h7,
        ST_EX2_IR   = 4'h8,
        ST_EX1_IR   = 4'h9,
        ST_SH_IR    = 4'hA,
        ST_PAUSE_IR = 4'hB,
        ST_RTI      = 4'hC,
        ST_UPD_IR   = 4'hD,
        ST_CAP_IR   = 4'hE,
        ST_TLR      = 4'hF
    } tap_state_e;

    typedef struct packed {
        logic cap_dr;
        logic sh_dr;
        logic upd_dr;
        logic cap_ir;
        logic sh_ir;
        logic upd_ir;
    } tap_dec_t;

    localparam logic [3:0] OPC_BYPASS  = 4'hF;
    localparam logic [3:0] OPC_INSCAN  = 4'h1;
    localparam logic [3:0] OPC_OUTSCAN = 4'h2;
    localparam logic [3:0] OPC_EXTEST  = 4'h3;
    localparam logic [3:0] OPC_TDRCFG  = 4'h4;
    localparam logic [3:0] IR_CAPTURE  = 4'h1;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        n = ST_TLR;
        case (s)
            ST_TLR:      n = tms ? ST_TLR    : ST_RTI;
            ST_RTI:      n = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR:   n = tms ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR:   n = tms ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:    n = tms ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR:   n = tms ? ST_UPD_DR : ST_PAUSE_DR;
            ST_PAUSE_DR: n = tms ? ST_EX2_DR : ST_PAUSE_DR;
            ST_EX2_DR:   n = tms ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR:   n = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR:   n = tms ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR:   n = tms ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:    n = tms ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR:   n = tms ? ST_UPD_IR : ST_PAUSE_IR;
            ST_PAUSE_IR: n = tms ? ST_EX2_IR : ST_PAUSE_IR;
            ST_EX2_IR:   n = tms ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR:   n = tms ? ST_SEL_DR : ST_RTI;
            default:     n = ST_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP state register with decoded state strobes and a look-ahead
// flag for the edge that enters Test-Logic-Reset.
module tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     tms,
    output tap_dec_t dec,
    output logic     next_is_tlr
);

    tap_state_e state_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_TLR;
        end else begin
            state_reg <= tap_next(state_reg, tms);
        end
    end

    // Lets the datapath apply TLR clears on the entering edge, not one cycle later.
    assign next_is_tlr = (tap_next(state_reg, tms) == ST_TLR);

    assign dec.cap_dr = (state_reg == ST_CAP_DR);
    assign dec.sh_dr  = (state_reg == ST_SH_DR);
    assign dec.upd_dr = (state_reg == ST_UPD_DR);
    assign dec.cap_ir = (state_reg == ST_CAP_IR);
    assign dec.sh_ir  = (state_reg == ST_SH_IR);
    assign dec.upd_ir = (state_reg == ST_UPD_IR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller front end for the boundary-scan wrapper chain: instruction
// register, bypass and wrapper-enable TDRs, chain strobes and the TDO mux.
module jtag_tap_ctrl
    import jtag_tap_pkg::*;
#(
    parameter int IR_W = 4
) (
    input  logic TDR_TCK,
    input  logic TDR_TRESETN,
    input  logic TMS,
    input  logic TDI,
    output logic TDO,
    output logic TDO_EN,
    output logic CTII,
    input  logic CTOO,
    output logic TDR_CAPTURE,
    output logic TDR_SHIFT,
    output logic TDR_UPDATE,
    output logic inscanwrap_sel,
    output logic outscanwrap_sel,
    output logic INSCANWRAP_TDR_EN,
    output logic OUTSCANWRAP_TDR_EN
);

    localparam logic [IR_W-1:0] IR_BYPASS  = IR_W'(OPC_BYPASS);
    localparam logic [IR_W-1:0] IR_INSCAN  = IR_W'(OPC_INSCAN);
    localparam logic [IR_W-1:0] IR_OUTSCAN = IR_W'(OPC_OUTSCAN);
    localparam logic [IR_W-1:0] IR_EXTEST  = IR_W'(OPC_EXTEST);
    localparam logic [IR_W-1:0] IR_TDRCFG  = IR_W'(OPC_TDRCFG);
    localparam logic [IR_W-1:0] IR_CAP     = IR_W'(IR_CAPTURE);

    tap_dec_t dec;
    logic     next_is_tlr;

    tap_fsm u_fsm (
        .clk         (TDR_TCK),
        .rst_n       (TDR_TRESETN),
        .tms         (TMS),
        .dec         (dec),
        .next_is_tlr (next_is_tlr)
    );

    logic [IR_W-1:0] ir_shift_reg;
    logic [IR_W-1:0] ir_reg;
    logic            bypass_reg;
    logic [1:0]      cfg_shift_reg;
    logic            in_en_reg;
    logic            out_en_reg;

    logic in_sel;
    logic out_sel;
    logic wrap_active;
    logic cfg_sel;

    assign in_sel      = (ir_reg == IR_INSCAN)  || (ir_reg == IR_EXTEST);
    assign out_sel     = (ir_reg == IR_OUTSCAN) || (ir_reg == IR_EXTEST);
    assign wrap_active = in_sel || out_sel;
    assign cfg_sel     = (ir_reg == IR_TDRCFG);

    always_ff @(posedge TDR_TCK or negedge TDR_TRESETN) begin
        if (!TDR_TRESETN) begin
            ir_shift_reg  <= IR_CAP;
            ir_reg        <= IR_BYPASS;
            bypass_reg    <= 1'b0;
            cfg_shift_reg <= 2'b00;
            in_en_reg     <= 1'b0;
            out_en_reg    <= 1'b0;
        end else begin
            if (dec.cap_ir) begin
                ir_shift_reg <= IR_CAP;
            end else if (dec.sh_ir) begin
                ir_shift_reg <= {TDI, ir_shift_reg[IR_W-1:1]};
            end

            if (next_is_tlr) begin
                ir_reg <= IR_BYPASS;
            end else if (dec.upd_ir) begin
                ir_reg <= ir_shift_reg;
            end

            // Wrapper instructions use the external chain, so no local DR moves.
            if (dec.cap_dr) begin
                bypass_reg <= 1'b0;
                if (cfg_sel) begin
                    cfg_shift_reg <= {out_en_reg, in_en_reg};
                end
            end else if (dec.sh_dr) begin
                if (cfg_sel) begin
                    cfg_shift_reg <= {TDI, cfg_shift_reg[1]};
                end else if (!wrap_active) begin
                    bypass_reg <= TDI;
                end
            end

            if (next_is_tlr) begin
                in_en_reg  <= 1'b0;
                out_en_reg <= 1'b0;
            end else if (dec.upd_dr && cfg_sel) begin
                in_en_reg  <= cfg_shift_reg[0];
                out_en_reg <= cfg_shift_reg[1];
            end
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (dec.sh_ir) begin
            TDO = ir_shift_reg[0];
        end else if (dec.sh_dr) begin
            if (wrap_active) begin
                TDO = CTOO;
            end else if (cfg_sel) begin
                TDO = cfg_shift_reg[0];
            end else begin
                TDO = bypass_reg;
            end
        end
    end

    assign TDO_EN             = dec.sh_dr || dec.sh_ir;
    assign CTII               = TDI;
    assign TDR_CAPTURE        = dec.cap_dr && wrap_active;
    assign TDR_SHIFT          = dec.sh_dr  && wrap_active;
    assign TDR_UPDATE         = dec.upd_dr && wrap_active;
    assign inscanwrap_sel     = in_sel;
    assign outscanwrap_sel    = out_sel;
    assign INSCANWRAP_TDR_EN  = in_en_reg;
    assign OUTSCANWRAP_TDR_EN = out_en_reg;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: expected TDO bits queued before each scan
// and popped as the DUT shifts them out; strobes counted on the falling edge.
module tb_jtag_tap_ctrl;
    import jtag_tap_pkg::*;

    logic tck    = 1'b0;
    logic trst_n = 1'b1;
    logic tms    = 1'b1;
    logic tdi    = 1'b0;
    logic ctoo   = 1'b0;
    logic tdo, tdo_en, ctii, cap, sh, upd, isel, osel, ien, oen;
    logic [8:0] outs;

    int checks = 0;
    int errors = 0;
    int cap_n = 0, sh_n = 0, upd_n = 0, en_n = 0;
    string tag_q[$];
    logic  exp_q[$];

    jtag_tap_ctrl #(.IR_W(4)) dut (
        .TDR_TCK            (tck),
        .TDR_TRESETN        (trst_n),
        .TMS                (tms),
        .TDI                (tdi),
        .TDO                (tdo),
        .TDO_EN             (tdo_en),
        .CTII               (ctii),
        .CTOO               (ctoo),
        .TDR_CAPTURE        (cap),
        .TDR_SHIFT          (sh),
        .TDR_UPDATE         (upd),
        .inscanwrap_sel     (isel),
        .outscanwrap_sel    (osel),
        .INSCANWRAP_TDR_EN  (ien),
        .OUTSCANWRAP_TDR_EN (oen)
    );

    assign outs = {tdo, tdo_en, cap, sh, upd, isel, osel, ien, oen};

    always #5 tck = ~tck;

    always @(negedge tck) begin
        if (cap === 1'b1)    cap_n++;
        if (sh === 1'b1)     sh_n++;
        if (upd === 1'b1)    upd_n++;
        if (tdo_en === 1'b1) en_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic obs);
        string t;
        logic  e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow observed=%b expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, {31'b0, obs}, {31'b0, e});
        end
    endtask

    task automatic clk1(input logic t);
        tms = t;
        @(posedge tck);
        #1;
    endtask

    task automatic shift_bit(input string tag, input logic d, input logic c, input logic last);
        tms  = last;
        tdi  = d;
        ctoo = c;
        #1;
        check({tag, "_tdo_en"}, {31'b0, tdo_en}, 1);
        check({tag, "_ctii"}, {31'b0, ctii}, {31'b0, d});
        sb_pop(tdo);
        @(posedge tck);
        #1;
    endtask

    // From RTI; ends in Update-IR. Capture value 0001 always shifts out first.
    task automatic load_ir(input logic [3:0] v);
        for (int i = 0; i < 4; i++) sb_push($sformatf("ir_out%0d", i), (i == 0));
        clk1(1'b1); clk1(1'b1); clk1(1'b0); clk1(1'b0);
        for (int i = 0; i < 4; i++) shift_bit("ir", v[i], 1'b0, (i == 3));
        clk1(1'b1);
        $display("load_ir 0x%0h", v);
    endtask

    // From RTI; ends in Update-DR.
    task automatic scan_dr(input int n, input logic [7:0] d, input logic [7:0] c,
                           input logic [7:0] e);
        for (int i = 0; i < n; i++) sb_push($sformatf("dr_out%0d", i), e[i]);
        clk1(1'b1); clk1(1'b0); clk1(1'b0);
        for (int i = 0; i < n; i++) shift_bit("dr", d[i], c[i], (i == n - 1));
        clk1(1'b1);
        $display("scan_dr n=%0d tdi=0x%0h ctoo=0x%0h", n, d, c);
    endtask

    initial begin
        int c0, s0, u0, e0;

        trst_n = 1'b0;
        #2;
        check("arst_outs", {23'b0, outs}, 0);
        check("arst_ir", {28'b0, dut.ir_reg}, 4'hF);
        @(negedge tck);
        trst_n = 1'b1;
        repeat (5) clk1(1'b1);
        check("tlr_state", {28'b0, dut.u_fsm.state_reg}, ST_TLR);
        check("tlr_outs", {23'b0, outs}, 0);
        check("tlr_ir", {28'b0, dut.ir_reg}, 4'hF);
        clk1(1'b0);

        // EXTEST and a 6-bit chain scan
        load_ir(4'h3);
        check("sel_before_upd_ir", {30'b0, isel, osel}, 2'b00);
        clk1(1'b0);
        check("sel_extest", {30'b0, isel, osel}, 2'b11);
        c0 = cap_n; s0 = sh_n; u0 = upd_n; e0 = en_n;
        scan_dr(6, 8'b0011_0110, 8'b0010_1101, 8'b0010_1101);
        clk1(1'b0);
        check("extest_cap_cycles", cap_n - c0, 1);
        check("extest_shift_cycles", sh_n - s0, 6);
        check("extest_upd_cycles", upd_n - u0, 1);
        check("extest_tdo_en_cycles", en_n - e0, 6);

        // TDRCFG: load enables = {out=1, in=0}, then read back
        load_ir(4'h4);
        clk1(1'b0);
        check("sel_tdrcfg", {30'b0, isel, osel}, 2'b00);
        c0 = cap_n; s0 = sh_n; u0 = upd_n;
        scan_dr(2, 8'b10, 8'b00, 8'b00);
        check("en_before_upd_dr", {30'b0, oen, ien}, 2'b00);
        clk1(1'b0);
        check("en_after_upd_dr", {30'b0, oen, ien}, 2'b10);
        check("tdrcfg_no_strobes", (cap_n - c0) + (sh_n - s0) + (upd_n - u0), 0);
        scan_dr(2, 8'b10, 8'b00, 8'b10);
        clk1(1'b0);
        check("en_rescan_hold", {30'b0, oen, ien}, 2'b10);

        // BYPASS: one-cycle delay, chain ignored, no strobes
        load_ir(4'hF);
        clk1(1'b0);
        c0 = cap_n; s0 = sh_n; u0 = upd_n; e0 = en_n;
        scan_dr(3, 8'b101, 8'b111, 8'b010);
        clk1(1'b0);
        check("bypass_no_strobes", (cap_n - c0) + (sh_n - s0) + (upd_n - u0), 0);
        check("bypass_tdo_en_cycles", en_n - e0, 3);
        check("en_kept_in_bypass", {30'b0, oen, ien}, 2'b10);

        // Pause-DR holds the bypass bit across several cycles
        sb_push("pause_cap", 1'b0);
        sb_push("pause_hold", 1'b1);
        clk1(1'b1); clk1(1'b0); clk1(1'b0);
        shift_bit("pause_a", 1'b1, 1'b0, 1'b1);
        tdi = 1'b0;
        clk1(1'b0); clk1(1'b0); clk1(1'b0);
        clk1(1'b1); clk1(1'b0);
        shift_bit("pause_b", 1'b0, 1'b0, 1'b1);
        clk1(1'b1); clk1(1'b0);
        $display("pause_dr scan");

        // Zero-shift IR scan updates to the capture value (INSCAN)
        clk1(1'b1); clk1(1'b1); clk1(1'b0); clk1(1'b1); clk1(1'b1);
        check("sel_before_zero_upd", {30'b0, isel, osel}, 2'b00);
        clk1(1'b0);
        check("sel_zero_shift", {30'b0, isel, osel}, 2'b10);
        $display("zero-shift ir update");

        // Clears land on the edge that enters TLR
        clk1(1'b1); clk1(1'b1);
        check("en_before_tlr", {30'b0, oen, ien}, 2'b10);
        clk1(1'b1);
        check("tlr_entry_state", {28'b0, dut.u_fsm.state_reg}, ST_TLR);
        check("tlr_entry_outs", {23'b0, outs}, 0);
        check("tlr_entry_ir", {28'b0, dut.ir_reg}, 4'hF);
        clk1(1'b0);
        $display("tms reset to tlr");

        // Async reset in the middle of an EXTEST shift
        load_ir(4'h4);
        clk1(1'b0);
        scan_dr(2, 8'b11, 8'b00, 8'b00);
        clk1(1'b0);
        check("en_both", {30'b0, oen, ien}, 2'b11);
        load_ir(4'h3);
        clk1(1'b0);
        sb_push("mid_dr0", 1'b1);
        sb_push("mid_dr1", 1'b0);
        clk1(1'b1); clk1(1'b0); clk1(1'b0);
        shift_bit("mid", 1'b1, 1'b1, 1'b0);
        shift_bit("mid", 1'b0, 1'b0, 1'b0);
        check("mid_shift_strobe", {31'b0, sh}, 1);
        trst_n = 1'b0;
        #1;
        check("mid_arst_outs", {23'b0, outs}, 0);
        check("mid_arst_state", {28'b0, dut.u_fsm.state_reg}, ST_TLR);
        check("mid_arst_ir", {28'b0, dut.ir_reg}, 4'hF);
        @(negedge tck);
        trst_n = 1'b1;
        repeat (5) clk1(1'b1);
        check("post_arst_outs", {23'b0, outs}, 0);
        $display("async reset mid-shift");

        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
